// File: rtl/uart_move_parser.sv
// Assembles ASCII Connect-6 move frames "r1c1r2c2" from a UART byte stream.
// Define MOVE_PARSER_SINGLE_STONE_EN to accept a four-digit single-stone opening move.
module uart_move_parser #(
  parameter int unsigned MAX_COORD = 19,
  parameter logic [7:0]  CR_CHAR   = 8'h0D,
  parameter logic [7:0]  LF_CHAR   = 8'h0A,
  parameter logic [7:0]  SP_CHAR   = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_eop,
  output logic       move_valid,
  input  logic       move_ready,
  output logic [4:0] move_r1,
  output logic [4:0] move_c1,
  output logic [4:0] move_r2,
  output logic [4:0] move_c2,
  output logic       move_two,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam logic [6:0] MaxCoord = 7'(MAX_COORD);

  typedef enum logic [1:0] {StIdle, StCollect, StDiscard, StHold} state_e;

  state_e     state;
  logic [3:0] cnt;
  logic [3:0] tens;
  logic [4:0] w_r1, w_c1, w_r2, w_c2;

  logic       is_digit, is_term, is_space, frame_end, coord_ok, single_ok;
  logic [3:0] digit_val;
  logic [6:0] coord_val;

  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term   = (rx_data == CR_CHAR) || (rx_data == LF_CHAR);
  assign is_space  = (rx_data == SP_CHAR);
  assign digit_val = rx_data[3:0];
  // A byte arriving together with rx_eop wins; the eop is ignored that cycle.
  assign frame_end = (rx_valid && is_term) || (rx_eop && !rx_valid);
  assign coord_val = 7'(tens) * 7'd10 + 7'(digit_val);
  assign coord_ok  = (coord_val >= 7'd1) && (coord_val <= MaxCoord);

`ifdef MOVE_PARSER_SINGLE_STONE_EN
  assign single_ok = (cnt == 4'd4);
`else
  assign single_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= 4'd0;
      tens       <= 4'd0;
      w_r1       <= 5'd0;
      w_c1       <= 5'd0;
      w_r2       <= 5'd0;
      w_c2       <= 5'd0;
      move_valid <= 1'b0;
      move_r1    <= 5'd0;
      move_c1    <= 5'd0;
      move_r2    <= 5'd0;
      move_c2    <= 5'd0;
      move_two   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (rx_valid) begin
            if (is_digit) begin
              tens  <= digit_val;
              cnt   <= 4'd1;
              state <= StCollect;
            end else if (!is_term && !is_space) begin
              frame_err <= 1'b1;
              err_code  <= 2'd0;
              state     <= StDiscard;
            end
          end
        end

        StCollect: begin
          if (frame_end) begin
            if (cnt == 4'd8) begin
              move_r1    <= w_r1;
              move_c1    <= w_c1;
              move_r2    <= w_r2;
              move_c2    <= w_c2;
              move_two   <= 1'b1;
              move_valid <= 1'b1;
              state      <= StHold;
            end else if (single_ok) begin
              move_r1    <= w_r1;
              move_c1    <= w_c1;
              move_r2    <= 5'd0;
              move_c2    <= 5'd0;
              move_two   <= 1'b0;
              move_valid <= 1'b1;
              state      <= StHold;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= StIdle;
            end
          end else if (rx_valid && is_digit) begin
            if (cnt == 4'd8) begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= StDiscard;
            end else if (!cnt[0]) begin
              tens <= digit_val;
              cnt  <= cnt + 4'd1;
            end else if (!coord_ok) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              state     <= StDiscard;
            end else begin
              // Odd counts 1,3,5,7 complete r1,c1,r2,c2 respectively.
              unique case (cnt[2:1])
                2'd0: w_r1 <= coord_val[4:0];
                2'd1: w_c1 <= coord_val[4:0];
                2'd2: w_r2 <= coord_val[4:0];
                2'd3: w_c2 <= coord_val[4:0];
              endcase
              cnt <= cnt + 4'd1;
            end
          end else if (rx_valid && !is_space) begin
            frame_err <= 1'b1;
            err_code  <= 2'd0;
            state     <= StDiscard;
          end
        end

        StDiscard: begin
          if (frame_end) begin
            state <= StIdle;
          end
        end

        StHold: begin
          if (rx_valid) begin
            overrun  <= 1'b1;
            err_code <= 2'd3;
          end
          if (move_ready) begin
            move_valid <= 1'b0;
            state      <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_move_parser.sv
// Directed bench for uart_move_parser: expected moves are queued as frames are sent and
// checked against the move outputs whenever move_valid is high.
module tb_uart_move_parser;

  logic       clk = 1'b0;
  logic       reset, rx_valid, rx_eop, move_ready;
  logic [7:0] rx_data;
  logic       move_valid, move_two, frame_err, overrun;
  logic [4:0] move_r1, move_c1, move_r2, move_c2;
  logic [1:0] err_code;

  uart_move_parser dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_eop     (rx_eop),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_r1    (move_r1),
    .move_c1    (move_c1),
    .move_r2    (move_r2),
    .move_c2    (move_c2),
    .move_two   (move_two),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] r1;
    logic [4:0] c1;
    logic [4:0] r2;
    logic [4:0] c2;
    logic       two;
  } move_t;

  move_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    fe_cnt      = 0;
  int    ov_cnt      = 0;
  int    acc_cnt     = 0;
  int    cyc         = 0;
  int    send_cyc    = 0;
  int    rise_cyc    = -1;
  logic  prev_mv     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic move_t mk(input int r1, input int c1, input int r2, input int c2,
                               input logic two);
    mk = '{r1: 5'(r1), c1: 5'(c1), r2: 5'(r2), c2: 5'(c2), two: two};
  endfunction

  // Runs at the negedge: sees outputs of the last edge and the inputs for the next one.
  task automatic observe();
    move_t e;
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (move_valid === 1'b1 && prev_mv !== 1'b1) rise_cyc = cyc;
    if (move_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_move", 32'(move_valid), 32'd0);
      end else begin
        e = exp_q[0];
        chk("move_fields", 32'({move_r1, move_c1, move_r2, move_c2, move_two}), 32'(e));
        if (move_ready === 1'b1) begin
          void'(exp_q.pop_front());
          acc_cnt++;
        end
      end
    end
    prev_mv = move_valid;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  // One byte followed by a one-cycle gap, as a real UART would space them.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cycle();
    send_cyc = cyc;
    rx_valid = 1'b0;
    cycle();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic pulse_eop();
    rx_eop = 1'b1;
    cycle();
    rx_eop = 1'b0;
    cycle();
  endtask

  int fe0, ov0, acc0, term_cyc;

  initial begin
    reset      = 1'b1;
    rx_valid   = 1'b0;
    rx_eop     = 1'b0;
    rx_data    = 8'h00;
    move_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    cycle();
    chk("rst_move_valid", 32'(move_valid), 0);
    chk("rst_fields", 32'({move_r1, move_c1, move_r2, move_c2, move_two}), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_pulses", 32'({frame_err, overrun}), 0);

    // Basic two-stone move, accepted immediately; trailing LF ignored.
    move_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt;
    exp_q.push_back(mk(3, 5, 10, 12, 1'b1));
    send_str("0305 1012\r");
    term_cyc = send_cyc;
    send(8'h0A);
    idle(2);
    chk("basic_latency", 32'(rise_cyc), 32'(term_cyc + 1));
    chk("basic_accepted", 32'(acc_cnt - acc0), 1);
    chk("basic_no_err", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);
    chk("basic_idle", 32'(move_valid), 0);
    chk("basic_retain", 32'({move_r1, move_c1, move_r2, move_c2}), 32'({5'd3, 5'd5, 5'd10, 5'd12}));

    // Range errors: 20 too big, 00 too small.
    fe0 = fe_cnt; acc0 = acc_cnt;
    send(8'h32);
    chk("range_first_digit", 32'(fe_cnt - fe0), 0);
    send(8'h30);
    chk("range_pulse", 32'(fe_cnt - fe0), 1);
    chk("range_code", 32'(err_code), 1);
    send_str("01\r");
    send_str("0001\r");
    idle(2);
    chk("range_pulses_total", 32'(fe_cnt - fe0), 2);
    chk("range_code2", 32'(err_code), 1);
    chk("range_no_move", 32'(acc_cnt - acc0), 0);

    // Short frame ended by eop, then a fresh frame with LF terminator.
    fe0 = fe_cnt; acc0 = acc_cnt;
    send_str("010203");
    pulse_eop();
    chk("count_pulse", 32'(fe_cnt - fe0), 1);
    chk("count_code", 32'(err_code), 2);
    exp_q.push_back(mk(19, 19, 18, 18, 1'b1));
    send_str("19191818\n");
    idle(2);
    chk("after_count_move", 32'(acc_cnt - acc0), 1);

    // Byte with simultaneous eop: byte wins, frame continues.
    acc0 = acc_cnt; fe0 = fe_cnt;
    exp_q.push_back(mk(1, 2, 3, 4, 1'b1));
    send_str("010");
    rx_data = 8'h32; rx_valid = 1'b1; rx_eop = 1'b1;
    cycle();
    rx_valid = 1'b0; rx_eop = 1'b0;
    cycle();
    send_str("0304");
    pulse_eop();
    idle(2);
    chk("eop_byte_move", 32'(acc_cnt - acc0), 1);
    chk("eop_byte_no_err", 32'(fe_cnt - fe0), 0);

    // Held move with a byte arriving: overrun, move untouched.
    move_ready = 1'b0;
    acc0 = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(mk(11, 12, 13, 14, 1'b1));
    send_str("11121314\r");
    idle(3);
    chk("hold_valid", 32'(move_valid), 1);
    send(8'h35);
    chk("overrun_pulse", 32'(ov_cnt - ov0), 1);
    chk("overrun_code", 32'(err_code), 3);
    chk("overrun_no_fe", 32'(fe_cnt - fe0), 0);
    chk("overrun_still_valid", 32'(move_valid), 1);
    move_ready = 1'b1;
    idle(2);
    chk("hold_accepted", 32'(acc_cnt - acc0), 1);
    chk("hold_released", 32'(move_valid), 0);

    // Illegal byte mid-frame: discard until CR, then parse normally.
    fe0 = fe_cnt; acc0 = acc_cnt;
    send_str("01x20304\r");
    chk("illegal_pulse", 32'(fe_cnt - fe0), 1);
    chk("illegal_code", 32'(err_code), 0);
    exp_q.push_back(mk(7, 7, 8, 8, 1'b1));
    send_str("0707 0808\r");
    idle(2);
    chk("after_illegal_move", 32'(acc_cnt - acc0), 1);

    // Ninth digit is a count error.
    fe0 = fe_cnt; acc0 = acc_cnt;
    send_str("010203040\r");
    idle(2);
    chk("nine_pulse", 32'(fe_cnt - fe0), 1);
    chk("nine_code", 32'(err_code), 2);
    chk("nine_no_move", 32'(acc_cnt - acc0), 0);

    // Reset mid-frame, then a four-digit frame.
    fe0 = fe_cnt; acc0 = acc_cnt;
    send_str("0102");
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle(2);
    chk("midreset_no_err", 32'(fe_cnt - fe0), 0);
    chk("midreset_outputs", 32'({move_valid, move_r1, err_code}), 0);
`ifdef MOVE_PARSER_SINGLE_STONE_EN
    exp_q.push_back(mk(1, 1, 0, 0, 1'b0));
    send_str("0101\r");
    idle(2);
    chk("single_move", 32'(acc_cnt - acc0), 1);
    chk("single_no_err", 32'(fe_cnt - fe0), 0);
`else
    send_str("0101\r");
    idle(2);
    chk("single_rejected", 32'(fe_cnt - fe0), 1);
    chk("single_code", 32'(err_code), 2);
    chk("single_no_move", 32'(acc_cnt - acc0), 0);
`endif

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_move_parser.md
Name: uart_move_parser

Overview:
Consumes the byte stream from the serial receiver (data-ready strobe, data byte, end-of-packet strobe) and assembles ASCII Connect-6 move frames.
- Frame format: row1 col1 row2 col2, each coordinate two decimal digits, 01..19.
- Validated moves are presented to the game engine on a valid/ready handshake.
- Malformed frames are reported with an error code.

Parameters:
- MAX_COORD, 19, largest legal row/column value (minimum is fixed at 1).
- CR_CHAR, 8'h0D, first terminator byte.
- LF_CHAR, 8'h0A, second terminator byte.
- SP_CHAR, 8'h20, separator byte; skipped everywhere.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe; rx_data is valid (driven from receiver data-ready)
- rx_data  in  8  received byte
- rx_eop  in  1  one-cycle strobe; line went idle (driven from receiver end-of-packet)
- move_valid  out  1  move is held on the move_* outputs
- move_ready  in  1  consumer accepts the move
- move_r1  out  5  row of stone 1
- move_c1  out  5  column of stone 1
- move_r2  out  5  row of stone 2
- move_c2  out  5  column of stone 2
- move_two  out  1  1 = two-stone move
- frame_err  out  1  one-cycle pulse; frame rejected
- err_code  out  2  cause of the last error; held until the next error: 0 non-digit, 1 range, 2 count, 3 overrun
- overrun  out  1  one-cycle pulse; byte dropped while a move was pending

Behaviour:
- Reset: all outputs 0; state IDLE; digit count 0.
- Byte classification: digit = 0x30..0x39; terminator = CR_CHAR or LF_CHAR; space = SP_CHAR; anything else = illegal.
- States and transitions:
  - IDLE:
    - digit -> store it, count=1, go COLLECT.
    - terminator, space, or rx_eop -> ignored.
    - illegal -> go DISCARD, err_code=0.
  - COLLECT, digit:
    - Even-position digit (tens) is latched.
    - Odd-position digit (ones) completes the coordinate: value = tens*10 + ones, 5-bit result.
    - If value < 1 or value > MAX_COORD -> DISCARD, err_code=1.
    - If count would reach 9 -> DISCARD, err_code=2.
    - Coordinates fill in order r1, c1, r2, c2.
  - COLLECT, space -> ignored.
  - COLLECT, illegal -> DISCARD, err_code=0.
  - COLLECT, terminator or rx_eop:
    - count==8 -> go HOLD.
    - any other count -> frame_err pulse, err_code=2, go IDLE.
  - DISCARD:
    - On terminator or rx_eop -> go IDLE.
    - frame_err pulses on entry to DISCARD, once per frame.
  - HOLD:
    - move_valid=1; move_* outputs stable.
    - move_two=1 (or per the optional feature).
    - move_valid && move_ready -> move_valid=0 next cycle, go IDLE.
    - Any rx_valid while in HOLD: byte dropped, overrun pulses, err_code=3. No frame_err; state stays HOLD.
- Latency: move_valid asserts the cycle after the terminator or rx_eop is sampled.
- Handshake: the move may be accepted in the same cycle move_valid first rises if move_ready is already high.
- Simultaneous rx_valid and rx_eop: the byte is processed and rx_eop is ignored that cycle.
- rx_eop in COLLECT with count==8 acts as a terminator.
- A CR immediately followed by LF yields one move; the LF is ignored in IDLE.
- Outputs do not change while move_valid is high. move_r*/c* retain their last accepted values after the handshake.
- Reset asserted mid-frame or in HOLD: state IDLE, move_valid=0, partial frame discarded, no error pulse.

Optional Feature:
MOVE_PARSER_SINGLE_STONE_EN
- Defined: a terminator or rx_eop at count==4 is accepted as the opening single-stone move.
  - HOLD with move_two=0, move_r2=0, move_c2=0.
  - count 2, 6 or 8 behaves as in the base behaviour (8 accepted; 2 and 6 give err_code=2).
- Undefined: count==4 is a count error (err_code=2); move_two is always 1.

Test Plan:
- Bytes "0305 1012\r", move_ready=1 -> move_valid one cycle after CR; r1=3, c1=5, r2=10, c2=12, move_two=1. LF then ignored; no error.
- Bytes "2001..." then CR -> frame_err pulse after the 2nd digit, err_code=1, no move. Repeat with "00": same result.
- Bytes "010203" then rx_eop -> frame_err, err_code=2, state IDLE. The next frame "19191818\n" -> r1=19, c1=19, r2=18, c2=18.
- Valid frame with move_ready=0, then byte 0x35 -> overrun pulse, err_code=3, move outputs unchanged. move_ready=1 -> accepted, then IDLE.
- Bytes "01x2..." -> frame_err, err_code=0. Digits are ignored until CR, then the next frame parses normally.
- Reset pulse after "0102" -> no move, no error. "0101\r":
  - with MOVE_PARSER_SINGLE_STONE_EN: move r1=1, c1=1, move_two=0.
  - without: err_code=2.
